// File: rtl/ahb_arbiter.sv
// Two-master AHB bus arbiter. Round-robin on ties, a bounded hold time while
// contested, and locked transfers. The address-phase and data-phase owners are pipelined.
module ahb_arbiter #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       HBUSREQ_1,
    input  logic       HBUSREQ_2,
    input  logic       HLOCK_1,
    input  logic       HLOCK_2,
    input  logic       HREADY,
    output logic       HGRANT_1,
    output logic       HGRANT_2,
    output logic [1:0] HMASTER,
    output logic [1:0] HMASTER_D,
    output logic       HMASTLOCK,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        M1   = 2'b01,
        M2   = 2'b10
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       last, last_nx;  // 0 = master 1 granted last, 1 = master 2

    // An owner's HLOCK is honoured only while it still requests. The other
    // master's lock is never looked at.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (HBUSREQ_1 && HBUSREQ_2) state_nx = last ? M1 : M2;
                else if (HBUSREQ_1)         state_nx = M1;
                else if (HBUSREQ_2)         state_nx = M2;
                else                        state_nx = IDLE;
            end
            M1: begin
                if (!HBUSREQ_1)
                    state_nx = HBUSREQ_2 ? M2 : IDLE;
                else if (!HLOCK_1 && HBUSREQ_2 && cnt == HOLD_LAST)
                    state_nx = M2;
            end
            M2: begin
                if (!HBUSREQ_2)
                    state_nx = HBUSREQ_1 ? M1 : IDLE;
                else if (!HLOCK_2 && HBUSREQ_1 && cnt == HOLD_LAST)
                    state_nx = M1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cnt_nx  = cnt;
        last_nx = last;
        if (state_nx != state || state == IDLE) cnt_nx = 4'd0;
        else if (cnt != HOLD_LAST)              cnt_nx = cnt + 4'd1;
        if (state_nx == M1) last_nx = 1'b0;
        if (state_nx == M2) last_nx = 1'b1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 1'b1;
            HGRANT_1  <= 1'b0;
            HGRANT_2  <= 1'b0;
            HMASTER   <= 2'b00;
            HMASTER_D <= 2'b00;
            HMASTLOCK <= 1'b0;
        end else if (HREADY) begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            last      <= last_nx;
            HGRANT_1  <= (state_nx == M1);
            HGRANT_2  <= (state_nx == M2);
            // The grant becomes the address phase, which becomes the data phase.
            HMASTER   <= {HGRANT_2, HGRANT_1};
            HMASTER_D <= HMASTER;
            HMASTLOCK <= (HGRANT_1 & HLOCK_1) | (HGRANT_2 & HLOCK_2);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed scenarios plus random traffic for ahb_arbiter. Every cycle is
// compared against an ownership-level reference model.
module tb_ahb_arbiter;

    localparam int MAX_HOLD = 4;

    logic       CLK, RST;
    logic       HBUSREQ_1, HBUSREQ_2, HLOCK_1, HLOCK_2, HREADY;
    logic       HGRANT_1, HGRANT_2, HMASTLOCK;
    logic [1:0] HMASTER, HMASTER_D, state_dbg;

    int checks = 0;
    int errors = 0;

    // Model: owner 0 = none, 1 = master 1, 2 = master 2.
    int         m_owner, m_hold, m_last;
    logic [1:0] m_mast, m_mast_d;
    logic       m_lock;

    ahb_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .CLK(CLK), .RST(RST),
        .HBUSREQ_1(HBUSREQ_1), .HBUSREQ_2(HBUSREQ_2),
        .HLOCK_1(HLOCK_1), .HLOCK_2(HLOCK_2), .HREADY(HREADY),
        .HGRANT_1(HGRANT_1), .HGRANT_2(HGRANT_2),
        .HMASTER(HMASTER), .HMASTER_D(HMASTER_D), .HMASTLOCK(HMASTLOCK),
        .state_dbg(state_dbg)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [1:0] onehot(input int o);
        return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_hold   = 0;
        m_last   = 2;
        m_mast   = 2'b00;
        m_mast_d = 2'b00;
        m_lock   = 1'b0;
    endtask

    task automatic model_edge();
        int  nxt, other;
        bit  rx, ro, lx;
        if (!HREADY) return;
        m_mast_d = m_mast;
        m_mast   = onehot(m_owner);
        m_lock   = (m_owner == 1 && HLOCK_1) || (m_owner == 2 && HLOCK_2);
        if (m_owner == 0) begin
            if (HBUSREQ_1 && HBUSREQ_2) nxt = 3 - m_last;
            else if (HBUSREQ_1)         nxt = 1;
            else if (HBUSREQ_2)         nxt = 2;
            else                        nxt = 0;
        end else begin
            other = 3 - m_owner;
            rx = (m_owner == 1) ? HBUSREQ_1 : HBUSREQ_2;
            ro = (m_owner == 1) ? HBUSREQ_2 : HBUSREQ_1;
            lx = (m_owner == 1) ? HLOCK_1 : HLOCK_2;
            if (rx && lx)                         nxt = m_owner;
            else if (!rx)                         nxt = ro ? other : 0;
            else if (ro && m_hold == MAX_HOLD - 1) nxt = other;
            else                                  nxt = m_owner;
        end
        if (nxt != m_owner) begin
            m_hold = 0;
            if (nxt != 0) m_last = nxt;
        end else if (m_owner != 0 && m_hold < MAX_HOLD - 1) begin
            m_hold++;
        end
        m_owner = nxt;
    endtask

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check(tag, {HGRANT_2, HGRANT_1, HMASTER, HMASTER_D, HMASTLOCK},
              {m_owner == 2, m_owner == 1, m_mast, m_mast_d, m_lock});
    endtask

    task automatic drive(input logic r1, input logic r2, input logic l1,
                         input logic l2, input logic rdy);
        HBUSREQ_1 = r1; HBUSREQ_2 = r2; HLOCK_1 = l1; HLOCK_2 = l2; HREADY = rdy;
    endtask

    // One clock: model and DUT see the same pre-edge inputs; sample 1 ns later.
    task automatic step(input string tag);
        @(posedge CLK);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        int g1_cycles;
        int waited;
        model_reset();
        drive(0, 0, 0, 0, 1);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset_state");
        RST = 1'b0;

        // Tie after reset: master 1 wins, holds for MAX_HOLD cycles, then master 2.
        drive(1, 1, 0, 0, 1);
        step("tie_e1");
        check("tie_grant1_e1", {6'd0, HGRANT_1}, 7'd1);
        g1_cycles = 1;
        step("tie_e2");
        check("tie_hmaster_e2", {5'd0, HMASTER}, 7'b01);
        if (HGRANT_1) g1_cycles++;
        step("tie_e3");
        check("tie_hmaster_d_e3", {5'd0, HMASTER_D}, 7'b01);
        if (HGRANT_1) g1_cycles++;
        for (int i = 0; i < 2; i++) begin
            step("tie_hold");
            if (HGRANT_1) g1_cycles++;
        end
        check("tie_g1_cycles", 7'(g1_cycles), 7'd4);
        check("tie_grant2_e5", {6'd0, HGRANT_2}, 7'd1);

        // Hand the bus to master 1, then master 1 locks against a contender.
        drive(1, 0, 0, 0, 1);
        step("to_m1");
        drive(1, 1, 1, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step("lock_hold");
            check("lock_grant1", {6'd0, HGRANT_1}, 7'd1);
        end
        check("lock_hmastlock", {6'd0, HMASTLOCK}, 7'd1);
        drive(1, 1, 0, 0, 1);
        waited = 0;
        for (int i = 0; i < 4 && !HGRANT_2; i++) begin
            step("unlock");
            waited++;
        end
        check("unlock_grant2", {6'd0, HGRANT_2}, 7'd1);

        // Wait states in the middle of a contested handover.
        drive(1, 1, 0, 0, 1);
        repeat (2) step("ws_pre");
        drive(1, 1, 0, 0, 0);
        repeat (3) step("ws_frozen");
        drive(1, 1, 0, 0, 1);
        repeat (6) step("ws_resume");

        // Let master 2 own the bus until its data phase is visible, then reset.
        drive(0, 1, 0, 0, 1);
        repeat (4) step("m2_own");
        check("pre_reset_hmaster_d", {5'd0, HMASTER_D}, 7'b10);
        #2 RST = 1'b1;
        #1;
        model_reset();
        check_all("async_reset");
        #1 RST = 1'b0;

        // Release: master 2 owns alone, then drops its request.
        drive(0, 1, 0, 0, 1);
        repeat (3) step("rel_own");
        drive(0, 0, 0, 0, 1);
        step("rel_e1");
        check("rel_grants", {5'd0, HGRANT_2, HGRANT_1}, 7'd0);
        step("rel_e2");
        check("rel_hmaster", {5'd0, HMASTER}, 7'd0);
        step("rel_e3");
        check("rel_hmaster_d", {5'd0, HMASTER_D}, 7'd0);

        // Single requester: no switch however long the hold counter runs.
        drive(0, 1, 0, 0, 1);
        step("single_entry");
        for (int i = 0; i < 20; i++) begin
            step("single");
            check("single_grant2", {5'd0, HGRANT_2, HGRANT_1}, 7'b10);
        end

        // Random traffic with stalls, locks and both request patterns.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0));
            step("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
